// File: rtl/srl_fifo_ctrl.sv
// Valid/ready FIFO controller for an external SRL16E bank with a registered FWFT output stage.
// Push to empty shows on the next edge; in_ready_o is registered and never looks at out_ready_i.
module srl_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0]       count_o,
    output logic [WIDTH-1:0] srl_d_o,
    output logic             srl_ce_o,
    output logic [3:0]       srl_a_o,
    input  logic [WIDTH-1:0] srl_q_i
);

    logic [4:0]       srl_cnt_q, srl_cnt_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic             in_rdy_q,  in_rdy_d;

    logic push, pop, load, srl_rd, bypass, srl_ce;

    always_comb begin
        push      = in_valid_i & in_rdy_q;
        pop       = out_vld_q & out_ready_i;
        load      = ~out_vld_q | pop;
        srl_rd    = load & (srl_cnt_q != 5'd0);
        // Only bypass when the SRLs are empty, otherwise an older word would be overtaken.
        bypass    = load & (srl_cnt_q == 5'd0) & push;
        srl_ce    = push & ~bypass;

        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (load) begin
            if (srl_rd) begin
                out_vld_d = 1'b1;
                out_dat_d = srl_q_i;
            end else if (bypass) begin
                out_vld_d = 1'b1;
                out_dat_d = in_data_i;
            end else begin
                out_vld_d = 1'b0;
            end
        end

        srl_cnt_d = srl_cnt_q + {4'd0, srl_ce} - {4'd0, srl_rd};
        in_rdy_d  = (srl_cnt_d < 5'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            srl_cnt_q <= 5'd0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            in_rdy_q  <= 1'b0;
        end else begin
            srl_cnt_q <= srl_cnt_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            in_rdy_q  <= in_rdy_d;
        end
    end

    // Oldest SRL word sits at address srl_cnt-1; address is a don't-care while empty.
    assign srl_a_o     = (srl_cnt_q != 5'd0) ? 4'(srl_cnt_q - 5'd1) : 4'd0;
    assign srl_d_o     = in_data_i;
    assign srl_ce_o    = srl_ce;
    assign in_ready_o  = in_rdy_q;
    assign out_valid_o = out_vld_q;
    assign out_data_o  = out_dat_q;
    assign count_o     = srl_cnt_q + {4'd0, out_vld_q};

endmodule
